// File: rtl/sao_stat_acc_nway.sv
// ---------------------------------------------------------------------------
// sao_stat_acc_nway
// SAO statistics collector for one band/edge category, NPIX pixels per beat.
// Each beat masks the pixels whose category equals cate_target. A registered
// adder tree sums the masked diffs and counts the matches. The per-beat
// results are accumulated over one CTU, and the totals are pulsed out when
// the CTU's last beat leaves the tree.
//
// Optional feature macro: SAO_STAT_SAT_EN
//   defined   -> accumulators clamp and sat_flag reports a clamp (sticky per CTU)
//   undefined -> accumulators wrap (two's complement) and sat_flag stays 0
//
// Ports
//   clk, arst_n      clock, asynchronous active-low reset
//   en               global advance; when low every register holds
//   start            clear accumulators and pipe valids, begin a new CTU
//   in_valid/in_last beat present / final beat of the CTU
//   cate_target      category being collected
//   cate[], diff[]   per-pixel category and signed clipped difference
//   busy             FSM not idle
//   out_valid        one-cycle pulse with sum_out/cnt_out
//   sum_out, cnt_out CTU totals, held until the next out_valid
//   sat_flag         an accumulator clamped during this CTU
// ---------------------------------------------------------------------------
module sao_stat_acc_nway #(
  parameter int NPIX   = 8,
  parameter int DIFF_W = 4,
  parameter int CATE_W = 5,
  parameter int ACC_W  = 18,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    en,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [CATE_W-1:0]       cate_target,
  input  logic [CATE_W-1:0]       cate [NPIX],
  input  logic signed [DIFF_W:0]  diff [NPIX],
  output logic                    busy,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] sum_out,
  output logic [CNT_W-1:0]        cnt_out,
  output logic                    sat_flag
);
  localparam int L      = $clog2(NPIX);
  localparam int SUM_W  = DIFF_W + 1 + L;
  localparam int TCNT_W = $clog2(NPIX + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Level 0 holds the masked diffs; level L element 0 is the tree result.
  // Every level is NPIX wide, and nodes beyond a level's population are
  // held at zero.
  logic signed [SUM_W-1:0]  sum_reg  [L+1][NPIX];
  logic signed [SUM_W-1:0]  sum_next [L+1][NPIX];
  logic [TCNT_W-1:0]        cnt_reg  [L+1][NPIX];
  logic [TCNT_W-1:0]        cnt_next [L+1][NPIX];
  logic [NPIX-1:0]          mask;

  logic [L:0]               vld_reg;
  logic [L:0]               lst_reg;
  logic [1:0]               state_reg;
  logic signed [ACC_W-1:0]  acc_sum_reg;
  logic signed [ACC_W-1:0]  acc_sum_next;
  logic [CNT_W-1:0]         acc_cnt_reg;
  logic [CNT_W-1:0]         acc_cnt_next;
  logic                     clamp;
  logic                     sat_reg;
  logic                     out_valid_reg;
  logic signed [ACC_W-1:0]  sum_out_reg;
  logic [CNT_W-1:0]         cnt_out_reg;
  logic                     accept;

  genvar gl, gi;

  generate
    for (gi = 0; gi < NPIX; gi++) begin : g_stage0
      assign mask[gi]        = (cate[gi] == cate_target);
      assign sum_next[0][gi] = mask[gi] ? SUM_W'(diff[gi]) : '0;
      assign cnt_next[0][gi] = mask[gi] ? TCNT_W'(1) : '0;
    end

    for (gl = 1; gl <= L; gl++) begin : g_lvl
      // Number of live nodes at the previous level: ceil(NPIX / 2^(gl-1)).
      localparam int NP = (NPIX + (1 << (gl - 1)) - 1) >> (gl - 1);
      for (gi = 0; gi < NPIX; gi++) begin : g_node
        if (2 * gi + 1 < NP) begin : g_add
          assign sum_next[gl][gi] = sum_reg[gl-1][2*gi] + sum_reg[gl-1][2*gi+1];
          assign cnt_next[gl][gi] = cnt_reg[gl-1][2*gi] + cnt_reg[gl-1][2*gi+1];
        end else if (2 * gi < NP) begin : g_pass
          // An odd element left over at this level passes through registered.
          assign sum_next[gl][gi] = sum_reg[gl-1][2*gi];
          assign cnt_next[gl][gi] = cnt_reg[gl-1][2*gi];
        end else begin : g_zero
          assign sum_next[gl][gi] = '0;
          assign cnt_next[gl][gi] = '0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int l = 0; l <= L; l++) begin
        for (int j = 0; j < NPIX; j++) begin
          sum_reg[l][j] <= '0;
          cnt_reg[l][j] <= '0;
        end
      end
    end else if (en) begin
      sum_reg <= sum_next;
      cnt_reg <= cnt_next;
    end
  end

`ifdef SAO_STAT_SAT_EN
  // One guard bit on each accumulator detects overflow before the clamp.
  logic signed [ACC_W:0] sum_wide;
  logic [CNT_W:0]        cnt_wide;
  logic                  sum_ovf;

  always_comb begin
    sum_wide     = (ACC_W+1)'(acc_sum_reg) + (ACC_W+1)'(sum_reg[L][0]);
    cnt_wide     = (CNT_W+1)'(acc_cnt_reg) + (CNT_W+1)'(cnt_reg[L][0]);
    sum_ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    acc_sum_next = sum_wide[ACC_W-1:0];
    if (sum_ovf) begin
      acc_sum_next = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
    end
    acc_cnt_next = cnt_wide[CNT_W] ? '1 : cnt_wide[CNT_W-1:0];
    clamp        = sum_ovf | cnt_wide[CNT_W];
  end
`else
  always_comb begin
    acc_sum_next = acc_sum_reg + ACC_W'(sum_reg[L][0]);
    acc_cnt_next = acc_cnt_reg + CNT_W'(cnt_reg[L][0]);
    clamp        = 1'b0;
  end
`endif

  // start opens a CTU from any state, so a beat presented with it is taken.
  assign accept = in_valid & (start | (state_reg == ST_ACCUM));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_reg       <= '0;
      lst_reg       <= '0;
      state_reg     <= ST_IDLE;
      acc_sum_reg   <= '0;
      acc_cnt_reg   <= '0;
      sat_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      sum_out_reg   <= '0;
      cnt_out_reg   <= '0;
    end else if (en) begin
      out_valid_reg <= 1'b0;
      lst_reg       <= {lst_reg[L-1:0], accept & in_last};
      if (start) begin
        // Abort any in-flight CTU: drop every beat still in the tree.
        vld_reg     <= (L+1)'(accept);
        acc_sum_reg <= '0;
        acc_cnt_reg <= '0;
        sat_reg     <= 1'b0;
        state_reg   <= (in_valid & in_last) ? ST_DRAIN : ST_ACCUM;
      end else begin
        vld_reg <= {vld_reg[L-1:0], accept};
        if (state_reg == ST_ACCUM && in_valid && in_last) begin
          state_reg <= ST_DRAIN;
        end
        if (vld_reg[L]) begin
          acc_sum_reg <= acc_sum_next;
          acc_cnt_reg <= acc_cnt_next;
          if (clamp) begin
            sat_reg <= 1'b1;
          end
          if (lst_reg[L]) begin
            sum_out_reg   <= acc_sum_next;
            cnt_out_reg   <= acc_cnt_next;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
      end
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign out_valid = out_valid_reg;
  assign sum_out   = sum_out_reg;
  assign cnt_out   = cnt_out_reg;
  assign sat_flag  = sat_reg;

endmodule

// File: tb/tb_sao_stat_acc_nway.sv
// Testbench for sao_stat_acc_nway. Two instances share the stimulus: dut_a
// uses the default ACC_W=18 and dut_b uses ACC_W=8 to exercise overflow.
// The stimulus pushes the expected totals and the expected pulse cycle into
// a queue per instance, and a negedge monitor per instance pops and compares.
module tb_sao_stat_acc_nway;
  localparam int NPIX   = 8;
  localparam int DIFF_W = 4;
  localparam int CATE_W = 5;
  localparam int D      = 4;

  typedef struct {
    string  tag;
    longint sum;
    longint cnt;
    bit     sat;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic en = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [CATE_W-1:0]      cate_target = 5'd3;
  logic [CATE_W-1:0]      cate [NPIX];
  logic signed [DIFF_W:0] diff [NPIX];

  logic               busy_a, ov_a, sat_a;
  logic signed [17:0] sum_a;
  logic [15:0]        cnt_a;
  logic               busy_b, ov_b, sat_b;
  logic signed [7:0]  sum_b;
  logic [15:0]        cnt_b;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  int c2 [NPIX] = '{3, 1, 3, 3, 0, 3, 2, 3};
  int d2 [NPIX] = '{5, -7, -16, 2, 9, 1, 4, -3};

  sao_stat_acc_nway dut_a (
    .clk(clk), .arst_n(arst_n), .en(en), .start(start), .in_valid(in_valid),
    .in_last(in_last), .cate_target(cate_target), .cate(cate), .diff(diff),
    .busy(busy_a), .out_valid(ov_a), .sum_out(sum_a), .cnt_out(cnt_a),
    .sat_flag(sat_a)
  );

  sao_stat_acc_nway #(.ACC_W(8)) dut_b (
    .clk(clk), .arst_n(arst_n), .en(en), .start(start), .in_valid(in_valid),
    .in_last(in_last), .cate_target(cate_target), .cate(cate), .diff(diff),
    .busy(busy_b), .out_valid(ov_b), .sum_out(sum_b), .cnt_out(cnt_b),
    .sat_flag(sat_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors: one per instance.
  always @(negedge clk) begin
    if (ov_a) begin
      if (q_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL a_unexpected: out_valid=1 sum=%0d cnt=%0d, expected no pulse (cycle %0d)",
                 sum_a, cnt_a, cyc);
      end else begin
        e_a = q_a.pop_front();
        $display("[TB] a %s: sum=%0d cnt=%0d sat=%0d cycle=%0d", e_a.tag, sum_a, cnt_a, sat_a, cyc);
        check({e_a.tag, "_a_sum"}, sum_a, e_a.sum);
        check({e_a.tag, "_a_cnt"}, cnt_a, e_a.cnt);
        check({e_a.tag, "_a_sat"}, sat_a, e_a.sat);
        check({e_a.tag, "_a_cyc"}, cyc, e_a.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (ov_b) begin
      if (q_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL b_unexpected: out_valid=1 sum=%0d cnt=%0d, expected no pulse (cycle %0d)",
                 sum_b, cnt_b, cyc);
      end else begin
        e_b = q_b.pop_front();
        $display("[TB] b %s: sum=%0d cnt=%0d sat=%0d cycle=%0d", e_b.tag, sum_b, cnt_b, sat_b, cyc);
        check({e_b.tag, "_b_sum"}, sum_b, e_b.sum);
        check({e_b.tag, "_b_cnt"}, cnt_b, e_b.cnt);
        check({e_b.tag, "_b_sat"}, sat_b, e_b.sat);
        check({e_b.tag, "_b_cyc"}, cyc, e_b.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int cv, input int dv);
    for (int i = 0; i < NPIX; i++) begin
      cate[i] = CATE_W'(cv);
      diff[i] = (DIFF_W+1)'(dv);
    end
  endtask

  // Present one beat for exactly one edge.
  task automatic beat(input bit st, input bit lst);
    start    = st;
    in_valid = 1'b1;
    in_last  = lst;
    step();
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push(input string tag, input longint sa, input longint ca,
                      input longint sb, input longint cb, input bit satb,
                      input int c);
    exp_t ea, eb;
    ea.tag = tag; ea.sum = sa; ea.cnt = ca; ea.sat = 1'b0; ea.cyc = c;
    eb.tag = tag; eb.sum = sb; eb.cnt = cb; eb.sat = satb; eb.cyc = c;
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 40 && (q_a.size() != 0 || q_b.size() != 0); i++) step();
    n_tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL %s_timeout: pending a=%0d b=%0d, expected 0/0", tag, q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
  endtask

  initial begin
    fill(0, 0);
    #2;
    check("rst_busy", busy_a, 0);
    check("rst_out_valid", ov_a, 0);
    check("rst_sum", sum_a, 0);
    check("rst_cnt", cnt_a, 0);
    check("rst_sat", sat_a, 0);
    step();
    step();
    arst_n = 1'b1;
    en     = 1'b1;
    step();

    // 1: single start+last beat, all pixels match with +15.
    fill(3, 15);
    beat(1'b1, 1'b1);
    push("t1", 120, 8, 120, 8, 1'b0, cyc + D);
    check("t1_busy", busy_a, 1);
    wait_done("t1");
    step();
    check("t1_idle", busy_a, 0);

    // 2: mixed categories and signs.
    for (int i = 0; i < NPIX; i++) begin
      cate[i] = CATE_W'(c2[i]);
      diff[i] = (DIFF_W+1)'(d2[i]);
    end
    beat(1'b1, 1'b1);
    push("t2", -11, 5, -11, 5, 1'b0, cyc + D);
    wait_done("t2");

    // 3: en low for three cycles while the beat is in flight.
    fill(3, 15);
    beat(1'b1, 1'b1);
    push("t3", 120, 8, 120, 8, 1'b0, cyc + D + 3);
    en = 1'b0;
    step();
    step();
    step();
    en = 1'b1;
    wait_done("t3");

    // 4: aborted CTU, then a restart with a single last beat.
    fill(3, 15);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    fill(3, 1);
    beat(1'b0, 1'b1);
    push("t4", 8, 8, 8, 8, 1'b0, cyc + D);
    wait_done("t4");
    for (int i = 0; i < 8; i++) step();

    // 5: ten beats of +120, overflows the ACC_W=8 instance.
    fill(3, 15);
    beat(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
`ifdef SAO_STAT_SAT_EN
    push("t5", 1200, 80, 127, 80, 1'b1, cyc + D);
`else
    push("t5", 1200, 80, -80, 80, 1'b0, cyc + D);
`endif
    wait_done("t5");

    // 6: reset during DRAIN clears outputs at once, no pulse after release.
    fill(3, 15);
    beat(1'b1, 1'b1);
    step();
    arst_n = 1'b0;
    #1;
    check("t6_busy", busy_a, 0);
    check("t6_out_valid", ov_a, 0);
    check("t6_sum", sum_a, 0);
    check("t6_cnt", cnt_a, 0);
    check("t6_b_sum", sum_b, 0);
    step();
    arst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("t6_idle", busy_a, 0);

    // 7: IDLE ignores a beat; a CTU with no matching pixels still reports.
    fill(3, 15);
    beat(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step();
    check("t7_idle_ignored", busy_a, 0);
    fill(0, 5);
    beat(1'b1, 1'b1);
    push("t7", 0, 0, 0, 0, 1'b0, cyc + D);
    wait_done("t7");
    for (int i = 0; i < 4; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
